// File: rtl/fnd_result_display_if.sv
// Capture bus between the calculator datapath and the FND display stage.
// The master drives a result word on a valid strobe; the slave answers with an update pulse.
interface fnd_result_display_if;
    logic       i_Valid;
    logic [3:0] i_Result;
    logic [1:0] i_Sel;
    logic       i_DivZero;
    logic       o_Updated;

    modport master (
        output i_Valid,
        output i_Result,
        output i_Sel,
        output i_DivZero,
        input  o_Updated
    );

    modport slave (
        input  i_Valid,
        input  i_Result,
        input  i_Sel,
        input  i_DivZero,
        output o_Updated
    );
endinterface

// File: rtl/fnd_result_display.sv
// Result display stage: latches a calculator result and its operation select,
// then scans it onto a 4-digit active-low multiplexed 7-segment module.
module fnd_result_display #(
    parameter int CLK_DIV = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    fnd_result_display_if.slave  bus,
    output logic [3:0]           o_FndCom,
    output logic [7:0]           o_FndFont
);

    localparam int TICK_W = $clog2(CLK_DIV);

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_E     = 8'h86;
    localparam logic [7:0] GLYPH_R     = 8'hAF;
    localparam logic [7:0] GLYPH_D     = 8'hA1;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } scan_t;

    scan_t             r_Digit;
    scan_t             w_DigitNext;
    logic [TICK_W-1:0] r_Tick;
    logic              w_TickDone;
    logic [3:0]        r_Value;
    logic [1:0]        r_Sel;
    logic              r_Err;
    logic              r_Updated;
    logic              w_Tens;
    logic [3:0]        w_Ones;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = 8'hC0;
            4'd1:    digit_glyph = 8'hF9;
            4'd2:    digit_glyph = 8'hA4;
            4'd3:    digit_glyph = 8'hB0;
            4'd4:    digit_glyph = 8'h99;
            4'd5:    digit_glyph = 8'h92;
            4'd6:    digit_glyph = 8'h82;
            4'd7:    digit_glyph = 8'hF8;
            4'd8:    digit_glyph = 8'h80;
            4'd9:    digit_glyph = 8'h90;
            default: digit_glyph = GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [7:0] op_glyph(input logic [1:0] sel);
        case (sel)
            2'b00:   op_glyph = 8'h88;
            2'b01:   op_glyph = 8'hBF;
            2'b10:   op_glyph = 8'h8C;
            default: op_glyph = GLYPH_D;
        endcase
    endfunction

    // Capture: divide-by-zero only means something for the divide operation.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_Value   <= 4'd0;
            r_Sel     <= 2'b00;
            r_Err     <= 1'b0;
            r_Updated <= 1'b0;
        end else begin
            r_Updated <= bus.i_Valid;
            if (bus.i_Valid) begin
                r_Value <= bus.i_Result;
                r_Sel   <= bus.i_Sel;
                r_Err   <= bus.i_DivZero & (bus.i_Sel == 2'b11);
            end
        end
    end

    assign bus.o_Updated = r_Updated;

    assign w_Tens = (r_Value >= 4'd10);
    assign w_Ones = w_Tens ? (r_Value - 4'd10) : r_Value;

    assign w_TickDone = (r_Tick == TICK_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_Tick  <= '0;
            r_Digit <= SCAN0;
        end else begin
            r_Tick  <= w_TickDone ? '0 : (r_Tick + TICK_W'(1));
            r_Digit <= w_DigitNext;
        end
    end

    always_comb begin
        w_DigitNext = r_Digit;
        if (w_TickDone) begin
            case (r_Digit)
                SCAN0:   w_DigitNext = SCAN1;
                SCAN1:   w_DigitNext = SCAN2;
                SCAN2:   w_DigitNext = SCAN3;
                default: w_DigitNext = SCAN0;
            endcase
        end
    end

    always_comb begin
        o_FndCom  = 4'b1110;
        o_FndFont = GLYPH_BLANK;
        case (r_Digit)
            SCAN0: begin
                o_FndCom  = 4'b1110;
                o_FndFont = r_Err ? GLYPH_R : digit_glyph(w_Ones);
            end
            SCAN1: begin
                o_FndCom  = 4'b1101;
                if (r_Err)
                    o_FndFont = GLYPH_R;
                else if (w_Tens)
                    o_FndFont = digit_glyph(4'd1);
                else
                    o_FndFont = GLYPH_BLANK;
            end
            SCAN2: begin
                o_FndCom  = 4'b1011;
                o_FndFont = r_Err ? GLYPH_E : GLYPH_BLANK;
            end
            default: begin
                o_FndCom  = 4'b0111;
                o_FndFont = r_Err ? GLYPH_D : op_glyph(r_Sel);
            end
        endcase
    end

endmodule

// File: tb/tb_fnd_result_display.sv
// Directed plus randomized check of the FND result display against a
// slot-by-slot model computed from elapsed cycles and the captured result.
module tb_fnd_result_display;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] fnd_com;
    logic [7:0] fnd_font;

    fnd_result_display_if bus ();

    fnd_result_display #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus),
        .o_FndCom  (fnd_com),
        .o_FndFont (fnd_font)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Edges seen since reset release; the active slot follows from this alone.
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [7:0] dig_glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] op_glyph  [4]  = '{8'h88, 8'hBF, 8'h8C, 8'hA1};

    int unsigned m_val;
    int unsigned m_sel;
    bit          m_err;

    function automatic logic [7:0] exp_font(input int unsigned slot);
        int unsigned tens;
        int unsigned ones;
        tens = m_val / 10;
        ones = m_val % 10;
        if (m_err) begin
            case (slot)
                0, 1:    return 8'hAF;
                2:       return 8'h86;
                default: return 8'hA1;
            endcase
        end
        case (slot)
            0:       return dig_glyph[ones];
            1:       return (tens == 1) ? dig_glyph[1] : 8'hFF;
            2:       return 8'hFF;
            default: return op_glyph[m_sel];
        endcase
    endfunction

    function automatic logic [3:0] exp_com(input int unsigned slot);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << slot;
        return ~one_hot;
    endfunction

    task automatic check_now(input string tag, input logic exp_upd);
        int unsigned slot;
        slot = (cyc / CLK_DIV) % 4;
        checks++;
        assert (fnd_com === exp_com(slot)) else begin
            errors++;
            $error("FAIL %s com: got %b expected %b (cyc %0d)", tag, fnd_com, exp_com(slot), cyc);
        end
        checks++;
        assert (fnd_font === exp_font(slot)) else begin
            errors++;
            $error("FAIL %s font slot%0d: got %h expected %h", tag, slot, fnd_font, exp_font(slot));
        end
        checks++;
        assert (bus.o_Updated === exp_upd) else begin
            errors++;
            $error("FAIL %s updated: got %b expected %b", tag, bus.o_Updated, exp_upd);
        end
    endtask

    task automatic check_frame(input string tag);
        repeat (4 * CLK_DIV) begin
            @(negedge clk);
            check_now(tag, 1'b0);
        end
    endtask

    task automatic model_capture(input int unsigned v, input int unsigned s, input bit dz);
        m_val = v;
        m_sel = s;
        m_err = dz && (s == 3);
    endtask

    task automatic drive(input logic [3:0] v, input logic [1:0] s, input logic dz);
        bus.i_Valid   = 1'b1;
        bus.i_Result  = v;
        bus.i_Sel     = s;
        bus.i_DivZero = dz;
    endtask

    task automatic capture(input string tag, input logic [3:0] v, input logic [1:0] s, input logic dz);
        @(posedge clk);
        #1 drive(v, s, dz);
        @(posedge clk);
        model_capture(v, s, dz);
        #1 bus.i_Valid = 1'b0;
        @(negedge clk);
        check_now({tag, "_pulse"}, 1'b1);
        @(negedge clk);
        check_now({tag, "_after"}, 1'b0);
    endtask

    initial begin
        bus.i_Valid   = 1'b0;
        bus.i_Result  = 4'd0;
        bus.i_Sel     = 2'b00;
        bus.i_DivZero = 1'b0;
        m_val = 0;
        m_sel = 0;
        m_err = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state and free-running scan.
        repeat (2) @(negedge clk);
        check_now("reset", 1'b0);
        rst_n = 1'b1;
        check_frame("scan");

        capture("add7", 4'd7, 2'b00, 1'b0);
        check_frame("add7");

        capture("mul13", 4'd13, 2'b10, 1'b0);
        check_frame("mul13");
        capture("mul10", 4'd10, 2'b10, 1'b0);
        check_frame("mul10");

        capture("div0", 4'd0, 2'b11, 1'b1);
        check_frame("div0");
        capture("div3", 4'd3, 2'b11, 1'b0);
        check_frame("div3");

        capture("sub15dz", 4'd15, 2'b01, 1'b1);
        check_frame("sub15dz");

        // Back-to-back strobes: both pulse, the second one wins.
        @(posedge clk);
        #1 drive(4'd9, 2'b00, 1'b0);
        @(posedge clk);
        model_capture(9, 0, 1'b0);
        #1 drive(4'd12, 2'b01, 1'b0);
        @(negedge clk);
        check_now("b2b_first", 1'b1);
        @(posedge clk);
        model_capture(12, 1, 1'b0);
        #1 bus.i_Valid = 1'b0;
        @(negedge clk);
        check_now("b2b_second", 1'b1);
        @(negedge clk);
        check_now("b2b_after", 1'b0);
        check_frame("b2b");

        // Randomized captures with idle gaps.
        for (int i = 0; i < 24; i++) begin
            logic [3:0] rv;
            logic [1:0] rs;
            logic       rdz;
            rv  = 4'($urandom_range(0, 15));
            rs  = 2'($urandom_range(0, 3));
            rdz = ($urandom_range(0, 2) == 0);
            capture("rand", rv, rs, rdz);
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                check_now("rand_idle", 1'b0);
            end
            check_frame("rand");
        end

        // Reset in the middle of slot 2 with a strobe pending.
        begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (!(((cyc / CLK_DIV) % 4) == 2 && (cyc % CLK_DIV) == 1) && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            checks++;
            assert (budget < 100) else begin
                errors++;
                $error("FAIL slot2_wait: got %0d cycles expected under 100", budget);
            end
        end
        drive(4'd9, 2'b10, 1'b0);
        rst_n = 1'b0;
        model_capture(0, 0, 1'b0);
        #1 check_now("rst_async", 1'b0);
        @(posedge clk);
        #1 check_now("rst_vs_valid", 1'b0);
        bus.i_Valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
